// File: rtl/interrupt_pkg.sv
// Shared defaults and helpers for the multi-channel interrupt controller.
package interrupt_pkg;

  localparam int DEFAULT_CHANNELS     = 4;
  localparam int DEFAULT_PULSE_CYCLES = 3;
  localparam int DEFAULT_SYNC_STAGES  = 2;

  // Width of a channel index; never narrower than one bit.
  function automatic int id_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/interrupt_sync_edge.sv
// One trigger bit: multi-flop synchroniser followed by a history flop,
// producing a single-cycle rise strobe in the clk domain.
module interrupt_sync_edge
  import interrupt_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic trigger,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the asynchronous trigger through the chain; remember the last synced value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Multi-channel interrupt controller: edge-detected triggers latch pending and
// overrun flags, a priority encoder reports the lowest pending channel, and a
// retriggerable down-counter stretches the CPU interrupt pulse.
module interrupt_ctrl
  import interrupt_pkg::*;
#(
  parameter int  N_CHANNELS   = DEFAULT_CHANNELS,
  parameter int  PULSE_CYCLES = DEFAULT_PULSE_CYCLES,
  parameter int  SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  localparam int ID_W         = id_width(N_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CHANNELS-1:0] trigger,
  input  logic [N_CHANNELS-1:0] enable,
  input  logic                  ack_valid,
  input  logic [ID_W-1:0]       ack_id,
  output logic                  interrupt,
  output logic [N_CHANNELS-1:0] pending,
  output logic [N_CHANNELS-1:0] overrun,
  output logic                  irq_valid,
  output logic [ID_W-1:0]       irq_id
);

  localparam int                 CNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(PULSE_CYCLES);
  localparam logic [ID_W:0]      ACK_LIM  = (ID_W + 1)'(N_CHANNELS);

  logic [N_CHANNELS-1:0] rise;
  logic [N_CHANNELS-1:0] set_vec;
  logic [N_CHANNELS-1:0] ack_vec;
  logic [N_CHANNELS-1:0] pending_q;
  logic [N_CHANNELS-1:0] overrun_q;
  logic [CNT_W-1:0]      cnt_q;

  for (genvar g = 0; g < N_CHANNELS; g++) begin : g_sync
    interrupt_sync_edge #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset  (reset),
      .trigger(trigger[g]),
      .rise   (rise[g])
    );
  end

  // Masked events; a rise on a disabled channel is simply lost.
  assign set_vec = rise & enable;

  // Decode the acknowledge into a one-hot clear; out-of-range ids clear nothing.
  always_comb begin
    ack_vec = '0;
    if (ack_valid && ({1'b0, ack_id} < ACK_LIM)) ack_vec[ack_id] = 1'b1;
  end

  // Pending/overrun flags: set beats ack, and an ack always retires the old overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      pending_q <= (pending_q & ~ack_vec) | set_vec;
      overrun_q <= (overrun_q & ~ack_vec) | (set_vec & pending_q & ~ack_vec);
    end
  end

  // Retriggerable pulse timer: reload on any accepted event, else count down to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (|set_vec) begin
      cnt_q <= CNT_LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Lowest-index pending channel wins; scan from the top so the last hit is the lowest.
  always_comb begin
    irq_id = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (pending_q[i]) irq_id = ID_W'(i);
    end
  end

  assign irq_valid = |pending_q;
  assign interrupt = (cnt_q != '0);
  assign pending   = pending_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl (4-channel main instance, 5-channel
// instance for out-of-range acknowledge ids).
module tb_interrupt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] trigger = '0;
  logic [3:0] enable = 4'b1111;
  logic       ack_valid = 1'b0;
  logic [1:0] ack_id = '0;
  logic       interrupt;
  logic [3:0] pending, overrun;
  logic       irq_valid;
  logic [1:0] irq_id;

  logic [4:0] trigger5 = '0;
  logic [4:0] enable5 = 5'b11111;
  logic       ack_valid5 = 1'b0;
  logic [2:0] ack_id5 = '0;
  logic       interrupt5;
  logic [4:0] pending5, overrun5;
  logic       irq_valid5;
  logic [2:0] irq_id5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  interrupt_ctrl #(.N_CHANNELS(4), .PULSE_CYCLES(3), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .trigger(trigger), .enable(enable),
    .ack_valid(ack_valid), .ack_id(ack_id), .interrupt(interrupt),
    .pending(pending), .overrun(overrun), .irq_valid(irq_valid), .irq_id(irq_id)
  );

  interrupt_ctrl #(.N_CHANNELS(5), .PULSE_CYCLES(3), .SYNC_STAGES(2)) dut5 (
    .clk(clk), .reset(reset), .trigger(trigger5), .enable(enable5),
    .ack_valid(ack_valid5), .ack_id(ack_id5), .interrupt(interrupt5),
    .pending(pending5), .overrun(overrun5), .irq_valid(irq_valid5), .irq_id(irq_id5)
  );

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ack4(input logic [1:0] id);
    ack_valid = 1'b1;
    ack_id    = id;
    tick();
    ack_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      trigger  = (k % 2 == 0) ? 4'b1111 : 4'b0000;
      trigger5 = (k % 2 == 0) ? 5'b11111 : 5'b00000;
      tick();
      checks++;
      if ({interrupt, pending, overrun, irq_valid, irq_id} !== 12'h000) begin
        errors++;
        $display("FAIL reset_hold: int=%b pend=%b ovr=%b v=%b id=%0d, expected all 0",
                 interrupt, pending, overrun, irq_valid, irq_id);
      end
    end
    trigger  = '0;
    trigger5 = '0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({interrupt, pending, overrun, irq_valid, irq_id} !== 12'h000) begin
        errors++;
        $display("FAIL reset_release: int=%b pend=%b ovr=%b v=%b id=%0d, expected all 0",
                 interrupt, pending, overrun, irq_valid, irq_id);
      end
    end
  endtask

  task automatic test_single_pulse();
    trigger[2] = 1'b1;
    tick(2);
    checks++;
    if (pending !== 4'b0000 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL single_early: pend=%b int=%b, expected 0000 0", pending, interrupt);
    end
    tick();
    checks++;
    if (pending !== 4'b0100 || irq_id !== 2'd2 || irq_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_pending: pend=%b id=%0d v=%b, expected 0100 2 1",
               pending, irq_id, irq_valid);
    end
    for (int e = 3; e <= 6; e++) begin
      checks++;
      if (interrupt !== (e <= 5)) begin
        errors++;
        $display("FAIL single_pulse_edge%0d: int=%b, expected %b", e, interrupt, (e <= 5));
      end
      tick();
    end
    trigger[2] = 1'b0;
    ack4(2'd2);
    checks++;
    if (pending !== 4'b0000 || irq_valid !== 1'b0 || irq_id !== 2'd0) begin
      errors++;
      $display("FAIL single_ack: pend=%b v=%b id=%0d, expected 0000 0 0",
               pending, irq_valid, irq_id);
    end
    tick(3);
  endtask

  task automatic test_priority();
    trigger = 4'b1010;
    tick(3);
    checks++;
    if (pending !== 4'b1010 || irq_id !== 2'd1) begin
      errors++;
      $display("FAIL prio_pending: pend=%b id=%0d, expected 1010 1", pending, irq_id);
    end
    trigger = 4'b0000;
    tick(4);
    ack4(2'd1);
    checks++;
    if (pending !== 4'b1000 || irq_id !== 2'd3 || interrupt !== 1'b0) begin
      errors++;
      $display("FAIL prio_after_ack: pend=%b id=%0d int=%b, expected 1000 3 0",
               pending, irq_id, interrupt);
    end
    tick();
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL prio_no_repulse: int=%b, expected 0", interrupt);
    end
    ack4(2'd3);
    tick(2);
  endtask

  task automatic test_mask_and_reload();
    int highs;
    enable     = 4'b1110;
    trigger[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (pending !== 4'b0000 || interrupt !== 1'b0) begin
        errors++;
        $display("FAIL mask_drop: pend=%b int=%b, expected 0000 0", pending, interrupt);
      end
    end
    enable = 4'b1111;
    tick(2);
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL mask_not_remembered: pend=%b, expected 0000", pending);
    end
    trigger[0] = 1'b0;
    tick(3);
    highs = 0;
    trigger[1] = 1'b1;
    tick(2);
    trigger[2] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (interrupt === 1'b1) highs++;
    end
    checks++;
    if (highs != 5) begin
      errors++;
      $display("FAIL reload_len: high cycles=%0d, expected 5", highs);
    end
    checks++;
    if (pending !== 4'b0110) begin
      errors++;
      $display("FAIL reload_pending: pend=%b, expected 0110", pending);
    end
    trigger = '0;
    ack4(2'd1);
    ack4(2'd2);
    tick(3);
  endtask

  task automatic test_overrun();
    trigger[3] = 1'b1;
    tick(3);
    checks++;
    if (pending !== 4'b1000 || overrun !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_first: pend=%b ovr=%b, expected 1000 0000", pending, overrun);
    end
    trigger[3] = 1'b0;
    tick(3);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL ovr_gap: int=%b, expected 0", interrupt);
    end
    trigger[3] = 1'b1;
    tick(3);
    checks++;
    if (overrun !== 4'b1000 || pending !== 4'b1000 || interrupt !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second: ovr=%b pend=%b int=%b, expected 1000 1000 1",
               overrun, pending, interrupt);
    end
    trigger[3] = 1'b0;
    tick(3);
    trigger[3] = 1'b1;
    tick(2);
    ack4(2'd3);
    checks++;
    if (pending !== 4'b1000 || overrun !== 4'b0000 || interrupt !== 1'b1) begin
      errors++;
      $display("FAIL ovr_ack_vs_set: pend=%b ovr=%b int=%b, expected 1000 0000 1",
               pending, overrun, interrupt);
    end
    trigger[3] = 1'b0;
    ack4(2'd3);
    checks++;
    if (pending !== 4'b0000) begin
      errors++;
      $display("FAIL ovr_final_ack: pend=%b, expected 0000", pending);
    end
    tick(3);

    trigger5[4] = 1'b1;
    tick(3);
    checks++;
    if (pending5 !== 5'b10000 || irq_id5 !== 3'd4) begin
      errors++;
      $display("FAIL n5_pending: pend=%b id=%0d, expected 10000 4", pending5, irq_id5);
    end
    for (int k = 5; k <= 7; k++) begin
      ack_valid5 = 1'b1;
      ack_id5    = 3'(k);
      tick();
      ack_valid5 = 1'b0;
      checks++;
      if (pending5 !== 5'b10000) begin
        errors++;
        $display("FAIL n5_ack_oor_%0d: pend=%b, expected 10000", k, pending5);
      end
    end
    ack_valid5 = 1'b1;
    ack_id5    = 3'd4;
    tick();
    ack_valid5 = 1'b0;
    checks++;
    if (pending5 !== 5'b00000 || irq_valid5 !== 1'b0) begin
      errors++;
      $display("FAIL n5_ack4: pend=%b v=%b, expected 00000 0", pending5, irq_valid5);
    end
    trigger5 = '0;
    tick(3);
  endtask

  task automatic test_reset_mid_pulse();
    trigger[1] = 1'b1;
    tick(3);
    trigger[1] = 1'b0;
    tick(3);
    trigger[1] = 1'b1;
    tick(3);
    checks++;
    if (overrun !== 4'b0010 || interrupt !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: ovr=%b int=%b, expected 0010 1", overrun, interrupt);
    end
    tick();
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("FAIL rst_second_cycle: int=%b, expected 1", interrupt);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (interrupt !== 1'b0 || pending !== 4'b0000 || overrun !== 4'b0000 || irq_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: int=%b pend=%b ovr=%b v=%b, expected 0 0000 0000 0",
               interrupt, pending, overrun, irq_valid);
    end
    trigger[1] = 1'b0;
    tick(2);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (pending !== 4'b0000 || interrupt !== 1'b0) begin
        errors++;
        $display("FAIL rst_quiet: pend=%b int=%b, expected 0000 0", pending, interrupt);
      end
    end
    trigger[1] = 1'b1;
    tick(3);
    checks++;
    if (pending !== 4'b0010 || interrupt !== 1'b1 || overrun !== 4'b0000) begin
      errors++;
      $display("FAIL rst_fresh_edge: pend=%b int=%b ovr=%b, expected 0010 1 0000",
               pending, interrupt, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_priority();
    test_mask_and_reload();
    test_overrun();
    test_reset_mid_pulse();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
